// File: rtl/ula_multiciclo_pkg.sv
// Shared opcodes, FSM state encodings and iterative-mode type for the multi-cycle ULA.
package ula_multiciclo_pkg;

    // Opcodes presented by the decoder
    localparam logic [3:0] ULA_ADD  = 4'b0000;
    localparam logic [3:0] ULA_SUB  = 4'b0001;
    localparam logic [3:0] ULA_MULT = 4'b0010;
    localparam logic [3:0] ULA_DIV  = 4'b0011;

    // Control FSM state encodings
    localparam logic [1:0] ULA_ST_IDLE = 2'd0;
    localparam logic [1:0] ULA_ST_CALC = 2'd1;
    localparam logic [1:0] ULA_ST_DONE = 2'd2;

    // Operation carried out by the shared iterative datapath
    typedef enum logic {
        MODE_MULT = 1'b0,
        MODE_DIV  = 1'b1
    } iter_mode_t;

    // True for the opcodes that need the multi-cycle datapath
    function automatic logic is_iterative(input logic [3:0] op);
        return (op == ULA_MULT) || (op == ULA_DIV);
    endfunction

endpackage

// File: rtl/ula_multiciclo_iterativa.sv
// Shared accumulator/shift datapath for MULT (MSB-first shift-add) and DIV
// (restoring division). Both walk the operand bits from WIDTH-1 down to 0.
// The top bit is processed on the start edge itself so that the final value
// is ready, and busy is already low, WIDTH cycles after start.
module ula_iterativa
    import ula_multiciclo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  iter_mode_t           mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic [2*WIDTH-1:0]   prod_or_qr
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] TOP_CNT = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    iter_mode_t         mode_q;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   next_cnt;

    // One iteration for bit position idx.
    // MULT: acc = 2*acc + (b[idx] ? a : 0)
    // DIV : acc = {remainder, quotient}; shift in a[idx], subtract b when it fits
    function automatic logic [2*WIDTH-1:0] step(
        input iter_mode_t         m,
        input logic [2*WIDTH-1:0] acc_in,
        input logic [WIDTH-1:0]   opa,
        input logic [WIDTH-1:0]   opb,
        input logic [IDX_W-1:0]   idx
    );
        logic [WIDTH:0]   rem_sh;
        logic [WIDTH-1:0] quo;
        if (m == MODE_MULT) begin
            return (acc_in << 1) + (opb[idx] ? (2*WIDTH)'(opa) : '0);
        end
        rem_sh = {acc_in[2*WIDTH-1:WIDTH], opa[idx]};
        quo    = acc_in[WIDTH-1:0];
        // Divide-by-zero always "fits": quotient fills with ones, remainder tracks a
        if (rem_sh >= {1'b0, opb}) begin
            rem_sh   = rem_sh - {1'b0, opb};
            quo[idx] = 1'b1;
        end
        return {rem_sh[WIDTH-1:0], quo};
    endfunction

    assign next_cnt   = cnt - 1'b1;
    assign prod_or_qr = acc;

    // Iteration control: cnt holds the bit index last processed, WIDTH-1 down to 0
    always_ff @(posedge clock) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= TOP_CNT;
        end else if (busy) begin
            cnt <= next_cnt;
            if (next_cnt == '0) begin
                busy <= 1'b0;
            end
        end
    end

    // Datapath: latch operands and do the first step on start, then one step per cycle
    always_ff @(posedge clock) begin
        if (start) begin
            a_q    <= a;
            b_q    <= b;
            mode_q <= mode;
            acc    <= step(mode, '0, a, b, TOP_IDX);
        end else if (busy) begin
            acc <= step(mode_q, acc, a_q, b_q, next_cnt[IDX_W-1:0]);
        end
    end

endmodule

// File: rtl/ula_multiciclo.sv
// Multi-cycle arithmetic unit: valid/ready in, valid/ready out.
// ADD/SUB/illegal finish in one cycle; MULT/DIV go through the shared
// iterative datapath for WIDTH cycles. Result is held until taken.
module ula_multiciclo
    import ula_multiciclo_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     operando1,
    input  logic [WIDTH-1:0]     operando2,
    input  logic [3:0]           opcode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 err
);

    logic [1:0]         state;
    logic               accept;
    logic               start;
    iter_mode_t         mode;
    logic               busy;
    logic [2*WIDTH-1:0] prod_or_qr;

    // Zero-extended sum, carry lands in bit WIDTH
    function automatic logic [2*WIDTH-1:0] add_ext(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        return (2*WIDTH)'(x) + (2*WIDTH)'(y);
    endfunction

    // Magnitude of the difference, so the result never wraps
    function automatic logic [2*WIDTH-1:0] abs_diff(
        input logic [WIDTH-1:0] x,
        input logic [WIDTH-1:0] y
    );
        return (x >= y) ? (2*WIDTH)'(x - y) : (2*WIDTH)'(y - x);
    endfunction

    assign in_ready  = (state == ULA_ST_IDLE);
    assign out_valid = (state == ULA_ST_DONE);
    assign accept    = in_valid && in_ready;
    assign start     = accept && is_iterative(opcode);
    assign mode      = (opcode == ULA_DIV) ? MODE_DIV : MODE_MULT;

    ula_iterativa #(
        .WIDTH(WIDTH)
    ) u_iter (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .a          (operando1),
        .b          (operando2),
        .busy       (busy),
        .prod_or_qr (prod_or_qr)
    );

    // Control FSM and output register; a reset mid-operation discards the result
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= ULA_ST_IDLE;
            result <= '0;
            err    <= 1'b0;
        end else begin
            case (state)
                ULA_ST_IDLE: begin
                    if (accept) begin
                        case (opcode)
                            ULA_ADD: begin
                                result <= add_ext(operando1, operando2);
                                err    <= 1'b0;
                                state  <= ULA_ST_DONE;
                            end
                            ULA_SUB: begin
                                result <= abs_diff(operando1, operando2);
                                err    <= 1'b0;
                                state  <= ULA_ST_DONE;
                            end
                            ULA_MULT, ULA_DIV: begin
                                err   <= (opcode == ULA_DIV) && (operando2 == '0);
                                state <= ULA_ST_CALC;
                            end
                            default: begin
                                result <= '0;
                                err    <= 1'b1;
                                state  <= ULA_ST_DONE;
                            end
                        endcase
                    end
                end
                ULA_ST_CALC: begin
                    if (!busy) begin
                        result <= prod_or_qr;
                        state  <= ULA_ST_DONE;
                    end
                end
                ULA_ST_DONE: begin
                    if (out_ready) begin
                        state <= ULA_ST_IDLE;
                    end
                end
                default: state <= ULA_ST_IDLE;
            endcase
        end
    end

endmodule
